onehot_decoder_fifo: RTL

//  Binary-to-one-hot decoder with valid/ready handshakes on both sides. It is
//  the inverse of the priority encoder: it takes an encoded index and drives
//  the matching one-hot vector. A DEPTH-entry FIFO sits between the two

---
 rtl/onehot_decoder_fifo.sv | 105 ++++++++++
 1 files changed

// File: rtl/onehot_decoder_fifo.sv
// Binary index to one-hot decoder feeding a DEPTH-entry FIFO with valid/ready on both sides; illegal indices set a sticky err.
// Optional even-parity check on {in_par, in_en, in_idx} enabled by defining DEC_PARITY_EN.
module onehot_decoder_fifo #(
    parameter int OUT_W = 4,
    parameter int IDX_W = 2,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IDX_W-1:0]         in_idx,
    input  logic                     in_en,
`ifdef DEC_PARITY_EN
    input  logic                     in_par,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_onehot,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err,
    input  logic                     err_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [IDX_W:0] OUT_W_X = OUT_W[IDX_W:0];

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;

    logic [OUT_W-1:0] dec_onehot;
    logic             idx_bad;
    logic             par_bad;
    logic             push, store, pop;

    // Out-of-range indices only exist when OUT_W is not a power of two.
    generate
        if (OUT_W == (1 << IDX_W)) begin : g_pow2
            assign idx_bad = 1'b0;
        end else begin : g_npow2
            assign idx_bad = ({1'b0, in_idx} >= OUT_W_X);
        end
    endgenerate

`ifdef DEC_PARITY_EN
    assign par_bad = ^{in_par, in_en, in_idx};
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        dec_onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            dec_onehot[i] = in_en && (in_idx == IDX_W'(i));
        end
    end

    assign in_ready   = (count_q != CW'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign out_onehot = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;
    assign err        = err_q;

    assign push  = in_valid && in_ready;
    assign store = push && !idx_bad && !par_bad;
    assign pop   = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (store) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
        case ({store, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A dropped word in the same cycle as err_clr keeps the flag raised.
        if (push && !store) err_d = 1'b1;
        else if (err_clr)   err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            if (store) mem_q[wr_ptr_q] <= dec_onehot;
        end
    end

endmodule
